// File: rtl/pipe_pkg.sv
// Shared encodings and the control bundle for the five-stage pipeline controller.
package pipe_pkg;

    localparam int unsigned PIPE_AW = 5;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned NPC_W   = 2;
    localparam int unsigned ALU_W   = 3;
    localparam int unsigned SRC_W   = 2;
    localparam int unsigned EXT_W   = 2;
    localparam int unsigned FWD_W   = 2;

    // Opcodes
    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BGTZ  = 6'h07;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'h0B;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [OP_W-1:0] FN_JR    = 6'h08;
    localparam logic [OP_W-1:0] FN_ADDU  = 6'h21;
    localparam logic [OP_W-1:0] FN_SUBU  = 6'h23;

    // Next-PC select
    localparam logic [NPC_W-1:0] NPC_PC4 = 2'b00;
    localparam logic [NPC_W-1:0] NPC_BR  = 2'b01;
    localparam logic [NPC_W-1:0] NPC_JAL = 2'b10;
    localparam logic [NPC_W-1:0] NPC_JR  = 2'b11;

    // ALU operations
    localparam logic [ALU_W-1:0] ALU_ADD  = 3'b000;
    localparam logic [ALU_W-1:0] ALU_SUB  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_OR   = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SLTU = 3'b100;
    localparam logic [ALU_W-1:0] ALU_BGTZ = 3'b101;

    // Write-back source
    localparam logic [SRC_W-1:0] SRC_ALU = 2'b00;
    localparam logic [SRC_W-1:0] SRC_MEM = 2'b01;
    localparam logic [SRC_W-1:0] SRC_PC8 = 2'b10;

    // Immediate extension
    localparam logic [EXT_W-1:0] EXT_SIGN = 2'b00;
    localparam logic [EXT_W-1:0] EXT_ZERO = 2'b01;
    localparam logic [EXT_W-1:0] EXT_LUI  = 2'b10;

    // Forward selects
    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b01;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b10;

    localparam logic [PIPE_AW-1:0] RA_ADDR = 5'd31;

    typedef struct packed {
        logic               reg_write;
        logic [SRC_W-1:0]   reg_src;
        logic [PIPE_AW-1:0] waddr;
        logic [ALU_W-1:0]   alu_op;
        logic               alu_src;
        logic               mem_write;
        logic               is_load;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

    // True when stage bundle c writes a nonzero register equal to addr.
    function automatic logic writes(input ctrl_bundle_t c, input logic [PIPE_AW-1:0] addr);
        return c.reg_write && (c.waddr == addr) && (addr != '0);
    endfunction

endpackage

// File: rtl/pipe_decode.sv
// ID-stage decoder: op/funct into a control bundle, register-read flags and PC-change kind.
module pipe_decode
    import pipe_pkg::*;
(
    input  logic [OP_W-1:0]    op,
    input  logic [OP_W-1:0]    funct,
    input  logic [PIPE_AW-1:0] rt,
    input  logic [PIPE_AW-1:0] rd,
    output ctrl_bundle_t       ctrl_c,
    output logic               rs_read_c,
    output logic               rt_read_c,
    output logic [EXT_W-1:0]   ext_op_c,
    output logic               is_branch_c,
    output logic               is_jal_c,
    output logic               is_jr_c
);

    // Instruction decode; anything unrecognised stays a bubble.
    always_comb begin
        ctrl_c      = CTRL_BUBBLE;
        rs_read_c   = 1'b0;
        rt_read_c   = 1'b0;
        ext_op_c    = EXT_SIGN;
        is_branch_c = 1'b0;
        is_jal_c    = 1'b0;
        is_jr_c     = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: begin
                        ctrl_c.reg_write = 1'b1;
                        ctrl_c.waddr     = rd;
                        ctrl_c.alu_op    = ALU_ADD;
                        rs_read_c        = 1'b1;
                        rt_read_c        = 1'b1;
                    end
                    FN_SUBU: begin
                        ctrl_c.reg_write = 1'b1;
                        ctrl_c.waddr     = rd;
                        ctrl_c.alu_op    = ALU_SUB;
                        rs_read_c        = 1'b1;
                        rt_read_c        = 1'b1;
                    end
                    FN_JR: begin
                        rs_read_c = 1'b1;
                        is_jr_c   = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_ORI: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.waddr     = rt;
                ctrl_c.alu_op    = ALU_OR;
                ctrl_c.alu_src   = 1'b1;
                rs_read_c        = 1'b1;
                ext_op_c         = EXT_ZERO;
            end
            OP_LW: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.reg_src   = SRC_MEM;
                ctrl_c.waddr     = rt;
                ctrl_c.alu_op    = ALU_ADD;
                ctrl_c.alu_src   = 1'b1;
                ctrl_c.is_load   = 1'b1;
                rs_read_c        = 1'b1;
            end
            OP_SW: begin
                ctrl_c.alu_op    = ALU_ADD;
                ctrl_c.alu_src   = 1'b1;
                ctrl_c.mem_write = 1'b1;
                rs_read_c        = 1'b1;
                rt_read_c        = 1'b1;
            end
            OP_BEQ: begin
                ctrl_c.alu_op = ALU_SUB;
                rs_read_c     = 1'b1;
                rt_read_c     = 1'b1;
                is_branch_c   = 1'b1;
            end
            OP_BGTZ: begin
                ctrl_c.alu_op = ALU_BGTZ;
                rs_read_c     = 1'b1;
                is_branch_c   = 1'b1;
            end
            OP_LUI: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.waddr     = rt;
                ctrl_c.alu_op    = ALU_ADD;
                ctrl_c.alu_src   = 1'b1;
                ext_op_c         = EXT_LUI;
            end
            OP_JAL: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.reg_src   = SRC_PC8;
                ctrl_c.waddr     = RA_ADDR;
                is_jal_c         = 1'b1;
            end
            OP_SLTIU: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.waddr     = rt;
                ctrl_c.alu_op    = ALU_SLTU;
                ctrl_c.alu_src   = 1'b1;
                rs_read_c        = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: ID decode, stage control registers, hazard stalls and forwarding selects.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter bit          FWD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        id_op,
    input  logic [5:0]        id_funct,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_cmp_zero,
    output logic [1:0]        id_npc_op,
    output logic [1:0]        id_ext_op,
    output logic              pc_ifid_en,
    output logic [1:0]        fwd_a_id,
    output logic [1:0]        fwd_b_id,
    output logic [1:0]        fwd_a_ex,
    output logic [1:0]        fwd_b_ex,
    output logic [2:0]        ex_alu_op,
    output logic              ex_alu_src,
    output logic              mem_write,
    output logic              wb_reg_write,
    output logic [1:0]        wb_reg_src,
    output logic [REG_AW-1:0] wb_waddr
);

    ctrl_bundle_t       dec_ctrl_c;
    logic               dec_rs_rd_c, dec_rt_rd_c;
    logic               dec_branch_c, dec_jal_c, dec_jr_c;
    logic [EXT_W-1:0]   dec_ext_c;

    ctrl_bundle_t       id_ex_q, ex_mem_q, mem_wb_q;
    logic [PIPE_AW-1:0] ex_rs_q, ex_rt_q;
    logic               ex_rs_rd_q, ex_rt_rd_q;

    logic [PIPE_AW-1:0] src_a, src_b;
    logic               a_ex, b_ex, a_mem, b_mem;
    logic               consume, load_use, br_stall, stall_c;
    logic               unused_wb;

    assign src_a = PIPE_AW'(id_rs);
    assign src_b = PIPE_AW'(id_rt);

    pipe_decode u_decode (
        .op          (id_op),
        .funct       (id_funct),
        .rt          (src_b),
        .rd          (PIPE_AW'(id_rd)),
        .ctrl_c      (dec_ctrl_c),
        .rs_read_c   (dec_rs_rd_c),
        .rt_read_c   (dec_rt_rd_c),
        .ext_op_c    (dec_ext_c),
        .is_branch_c (dec_branch_c),
        .is_jal_c    (dec_jal_c),
        .is_jr_c     (dec_jr_c)
    );

    // RAW hazard detection against EX and MEM, stall decision and ID-side forwarding.
    always_comb begin
        consume  = dec_branch_c || dec_jr_c;
        a_ex     = dec_rs_rd_c && writes(id_ex_q, src_a);
        b_ex     = dec_rt_rd_c && writes(id_ex_q, src_b);
        a_mem    = dec_rs_rd_c && writes(ex_mem_q, src_a);
        b_mem    = dec_rt_rd_c && writes(ex_mem_q, src_b);
        load_use = id_ex_q.is_load && (a_ex || b_ex);
        br_stall = consume && (a_ex || b_ex || (ex_mem_q.is_load && (a_mem || b_mem)));
        if (FWD_EN) begin
            stall_c = load_use || br_stall;
        end else begin
            // Write-before-read regfile covers a WB writer, so only EX/MEM stall.
            stall_c = a_ex || b_ex || a_mem || b_mem;
        end
        pc_ifid_en = !stall_c;

        fwd_a_id = FWD_RF;
        fwd_b_id = FWD_RF;
        if (FWD_EN && consume && !ex_mem_q.is_load) begin
            if (a_mem) fwd_a_id = FWD_MEM;
            if (b_mem) fwd_b_id = FWD_MEM;
        end
    end

    // Next-PC select; a stall suppresses the decision so it is re-made next cycle.
    always_comb begin
        id_npc_op = NPC_PC4;
        id_ext_op = dec_ext_c;
        if (!stall_c) begin
            if (dec_branch_c && id_cmp_zero) id_npc_op = NPC_BR;
            else if (dec_jal_c)              id_npc_op = NPC_JAL;
            else if (dec_jr_c)               id_npc_op = NPC_JR;
        end
    end

    // EX operand forwarding: MEM result beats WB write data.
    always_comb begin
        fwd_a_ex = FWD_RF;
        fwd_b_ex = FWD_RF;
        if (FWD_EN) begin
            if (ex_rs_rd_q && writes(ex_mem_q, ex_rs_q))      fwd_a_ex = FWD_MEM;
            else if (ex_rs_rd_q && writes(mem_wb_q, ex_rs_q)) fwd_a_ex = FWD_WB;
            if (ex_rt_rd_q && writes(ex_mem_q, ex_rt_q))      fwd_b_ex = FWD_MEM;
            else if (ex_rt_rd_q && writes(mem_wb_q, ex_rt_q)) fwd_b_ex = FWD_WB;
        end
    end

    // Stage registers; a stall turns the ID/EX load into a bubble while later stages advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_q    <= CTRL_BUBBLE;
            ex_mem_q   <= CTRL_BUBBLE;
            mem_wb_q   <= CTRL_BUBBLE;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_rs_rd_q <= 1'b0;
            ex_rt_rd_q <= 1'b0;
        end else begin
            ex_mem_q <= id_ex_q;
            mem_wb_q <= ex_mem_q;
            if (stall_c) begin
                id_ex_q    <= CTRL_BUBBLE;
                ex_rs_q    <= '0;
                ex_rt_q    <= '0;
                ex_rs_rd_q <= 1'b0;
                ex_rt_rd_q <= 1'b0;
            end else begin
                id_ex_q    <= dec_ctrl_c;
                ex_rs_q    <= src_a;
                ex_rt_q    <= src_b;
                ex_rs_rd_q <= dec_rs_rd_c;
                ex_rt_rd_q <= dec_rt_rd_c;
            end
        end
    end

    assign ex_alu_op    = id_ex_q.alu_op;
    assign ex_alu_src   = id_ex_q.alu_src;
    assign mem_write    = ex_mem_q.mem_write;
    assign wb_reg_write = mem_wb_q.reg_write;
    assign wb_reg_src   = mem_wb_q.reg_src;
    assign wb_waddr     = REG_AW'(mem_wb_q.waddr);

    // Bundle fields that have no consumer once they reach WB.
    assign unused_wb = ^{mem_wb_q.alu_op, mem_wb_q.alu_src, mem_wb_q.mem_write, mem_wb_q.is_load};

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed vector bench for pipe_ctrl with forwarding on (dut1) and off (dut0).
module tb_pipe_ctrl;
    import pipe_pkg::*;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [4:0]  rs, rt, rd;
        logic        cmp;
        logic [25:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [5:0] op1, fn1, op0, fn0;
    logic [4:0] rs1, rt1, rd1, rs0, rt0, rd0;
    logic       cmp1, cmp0;

    logic [1:0] npc1, ext1, fai1, fbi1, fae1, fbe1, rsrc1;
    logic [1:0] npc0, ext0, fai0, fbi0, fae0, fbe0, rsrc0;
    logic [2:0] alu1, alu0;
    logic       en1, src1, mw1, rw1, en0, src0, mw0, rw0;
    logic [4:0] wa1, wa0;
    logic [25:0] obs1, obs0;

    assign obs1 = {npc1, ext1, en1, fai1, fbi1, fae1, fbe1, alu1, src1, mw1, rw1, rsrc1, wa1};
    assign obs0 = {npc0, ext0, en0, fai0, fbi0, fae0, fbe0, alu0, src0, mw0, rw0, rsrc0, wa0};

    pipe_ctrl #(.REG_AW(5), .FWD_EN(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_op(op1), .id_funct(fn1), .id_rs(rs1), .id_rt(rt1),
        .id_rd(rd1), .id_cmp_zero(cmp1), .id_npc_op(npc1), .id_ext_op(ext1), .pc_ifid_en(en1),
        .fwd_a_id(fai1), .fwd_b_id(fbi1), .fwd_a_ex(fae1), .fwd_b_ex(fbe1), .ex_alu_op(alu1),
        .ex_alu_src(src1), .mem_write(mw1), .wb_reg_write(rw1), .wb_reg_src(rsrc1), .wb_waddr(wa1)
    );

    pipe_ctrl #(.REG_AW(5), .FWD_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .id_op(op0), .id_funct(fn0), .id_rs(rs0), .id_rt(rt0),
        .id_rd(rd0), .id_cmp_zero(cmp0), .id_npc_op(npc0), .id_ext_op(ext0), .pc_ifid_en(en0),
        .fwd_a_id(fai0), .fwd_b_id(fbi0), .fwd_a_ex(fae0), .fwd_b_ex(fbe0), .ex_alu_op(alu0),
        .ex_alu_src(src0), .mem_write(mw0), .wb_reg_write(rw0), .wb_reg_src(rsrc0), .wb_waddr(wa0)
    );

    int n_vec  = 0;
    int n_fail = 0;
    vec_t va[$];
    vec_t vb[$];

    localparam logic [5:0] R = 6'h00;

    // Row: instruction fields, then npc,ext,en,fwd_a_id,fwd_b_id,fwd_a_ex,fwd_b_ex,alu,src,mw,rw,rsrc,waddr.
    function automatic vec_t mkv(input int op, input int fn, input int rs, input int rt, input int rd,
                                 input int cmp, input int npc, input int ext, input int en,
                                 input int fai, input int fbi, input int fae, input int fbe,
                                 input int alu, input int src, input int mw, input int rw,
                                 input int rsrc, input int wa);
        vec_t v;
        v.op    = 6'(op);
        v.funct = 6'(fn);
        v.rs    = 5'(rs);
        v.rt    = 5'(rt);
        v.rd    = 5'(rd);
        v.cmp   = 1'(cmp);
        v.exp   = {2'(npc), 2'(ext), 1'(en), 2'(fai), 2'(fbi), 2'(fae), 2'(fbe),
                   3'(alu), 1'(src), 1'(mw), 1'(rw), 2'(rsrc), 5'(wa)};
        return v;
    endfunction

    task automatic drive(input vec_t v, input bit which);
        if (which) begin
            op1 = v.op; fn1 = v.funct; rs1 = v.rs; rt1 = v.rt; rd1 = v.rd; cmp1 = v.cmp;
        end else begin
            op0 = v.op; fn0 = v.funct; rs0 = v.rs; rt0 = v.rt; rd0 = v.rd; cmp0 = v.cmp;
        end
    endtask

    task automatic check(input string name, input int idx, input bit which, input logic [25:0] exp);
        logic [25:0] act;
        act = which ? obs1 : obs0;
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] fwd_en=%0d: got %h (npc=%b en=%b fid=%b%b fex=%b%b) expected %h",
                     name, idx, which, act, act[25:24], act[21], act[20:19], act[18:17],
                     act[16:15], act[14:13], exp);
        end
    endtask

    task automatic run_table(input string name, input bit which, input vec_t tbl[$]);
        foreach (tbl[i]) begin
            drive(tbl[i], which);
            @(negedge clk);
            check(name, i, which, tbl[i].exp);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vec_t nop;
        nop = mkv(0,0,0,0,0,0, 0,0,1,0,0,0,0,0,0,0,0,0,0);

        // Forwarding enabled
        va.push_back(mkv(R,FN_ADDU,1,2,3,0,     0,0,1,0,0,0,0,0,0,0,0,0,0));
        va.push_back(mkv(R,FN_SUBU,3,1,4,0,     0,0,1,0,0,0,0,0,0,0,0,0,0));
        va.push_back(mkv(R,FN_ADDU,0,3,5,0,     0,0,1,0,0,1,0,1,0,0,0,0,0));
        va.push_back(mkv(0,0,0,0,0,0,           0,0,1,0,0,0,2,0,0,0,1,0,3));
        va.push_back(mkv(OP_LW,0,0,5,0,0,       0,0,1,0,0,0,0,0,0,0,1,0,4));
        va.push_back(mkv(R,FN_ADDU,5,5,6,0,     0,0,0,0,0,0,0,0,1,0,1,0,5));
        va.push_back(mkv(R,FN_ADDU,5,5,6,0,     0,0,1,0,0,0,0,0,0,0,0,0,0));
        va.push_back(mkv(0,0,0,0,0,0,           0,0,1,0,0,2,2,0,0,0,1,1,5));
        va.push_back(mkv(R,FN_ADDU,1,2,7,0,     0,0,1,0,0,0,0,0,0,0,0,0,0));
        va.push_back(mkv(OP_BEQ,0,7,0,0,1,      0,0,0,0,0,0,0,0,0,0,1,0,6));
        va.push_back(mkv(OP_BEQ,0,7,0,0,1,      1,0,1,1,0,0,0,0,0,0,0,0,0));
        va.push_back(mkv(OP_LW,0,0,7,0,0,       0,0,1,0,0,2,0,1,0,0,1,0,7));
        va.push_back(mkv(OP_BEQ,0,7,0,0,1,      0,0,0,0,0,0,0,0,1,0,0,0,0));
        va.push_back(mkv(OP_BEQ,0,7,0,0,1,      0,0,0,0,0,0,0,0,0,0,0,0,0));
        va.push_back(mkv(OP_BEQ,0,7,0,0,1,      1,0,1,0,0,0,0,0,0,0,1,1,7));
        va.push_back(mkv(OP_JAL,0,0,0,0,0,      2,0,1,0,0,0,0,1,0,0,0,0,0));
        va.push_back(mkv(R,FN_JR,31,0,0,0,      0,0,0,0,0,0,0,0,0,0,0,0,0));
        va.push_back(mkv(R,FN_JR,31,0,0,0,      3,0,1,1,0,0,0,0,0,0,0,0,0));
        va.push_back(mkv(OP_SW,0,31,2,0,0,      0,0,1,0,0,2,0,0,0,0,1,2,31));
        va.push_back(mkv(0,0,0,0,0,0,           0,0,1,0,0,0,0,0,1,0,0,0,0));
        va.push_back(mkv(R,FN_ADDU,1,2,0,0,     0,0,1,0,0,0,0,0,0,1,0,0,0));
        va.push_back(mkv(R,FN_SUBU,0,0,8,0,     0,0,1,0,0,0,0,0,0,0,0,0,0));
        va.push_back(mkv(OP_ORI,0,8,9,0,0,      0,1,1,0,0,0,0,1,0,0,0,0,0));
        va.push_back(mkv(OP_LUI,0,0,10,0,0,     0,2,1,0,0,1,0,2,1,0,1,0,0));
        va.push_back(mkv(OP_SLTIU,0,10,11,0,0,  0,0,1,0,0,0,0,0,1,0,1,0,8));
        va.push_back(mkv(OP_BGTZ,0,11,0,0,0,    0,0,0,0,0,1,0,4,1,0,1,0,9));
        va.push_back(mkv(OP_BGTZ,0,11,0,0,0,    0,0,1,1,0,0,0,0,0,0,1,0,10));
        va.push_back(mkv(6'h3F,0,1,2,3,1,       0,0,1,0,0,2,0,5,0,0,1,0,11));
        va.push_back(mkv(0,0,0,0,0,0,           0,0,1,0,0,0,0,0,0,0,0,0,0));
        va.push_back(mkv(0,0,0,0,0,0,           0,0,1,0,0,0,0,0,0,0,0,0,0));

        // Forwarding disabled
        vb.push_back(mkv(R,FN_ADDU,1,2,3,0,     0,0,1,0,0,0,0,0,0,0,0,0,0));
        vb.push_back(mkv(R,FN_SUBU,3,1,4,0,     0,0,0,0,0,0,0,0,0,0,0,0,0));
        vb.push_back(mkv(R,FN_SUBU,3,1,4,0,     0,0,0,0,0,0,0,0,0,0,0,0,0));
        vb.push_back(mkv(R,FN_SUBU,3,1,4,0,     0,0,1,0,0,0,0,0,0,0,1,0,3));
        vb.push_back(mkv(R,FN_ADDU,3,4,5,0,     0,0,0,0,0,0,0,1,0,0,0,0,0));
        vb.push_back(mkv(R,FN_ADDU,3,4,5,0,     0,0,0,0,0,0,0,0,0,0,0,0,0));
        vb.push_back(mkv(R,FN_ADDU,3,4,5,0,     0,0,1,0,0,0,0,0,0,0,1,0,4));
        vb.push_back(mkv(R,FN_ADDU,1,2,0,0,     0,0,1,0,0,0,0,0,0,0,0,0,0));
        vb.push_back(mkv(R,FN_ADDU,0,0,6,0,     0,0,1,0,0,0,0,0,0,0,0,0,0));
        vb.push_back(mkv(OP_BEQ,0,6,0,0,1,      0,0,0,0,0,0,0,0,0,0,1,0,5));
        vb.push_back(mkv(OP_BEQ,0,6,0,0,1,      0,0,0,0,0,0,0,0,0,0,1,0,0));
        vb.push_back(mkv(OP_BEQ,0,6,0,0,1,      1,0,1,0,0,0,0,0,0,0,1,0,6));
        vb.push_back(mkv(0,0,0,0,0,0,           0,0,1,0,0,0,0,1,0,0,0,0,0));
        vb.push_back(mkv(0,0,0,0,0,0,           0,0,1,0,0,0,0,0,0,0,0,0,0));

        // Power-on reset
        rst_n = 1'b0;
        drive(nop, 1'b1);
        drive(nop, 1'b0);
        #12;
        check("reset", 0, 1'b1, nop.exp);
        check("reset", 0, 1'b0, nop.exp);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_table("fwd_on", 1'b1, va);
        run_table("fwd_off", 1'b0, vb);

        // Reset asserted in the middle of a load-use stall
        drive(mkv(OP_LW,0,0,5,0,0, 0,0,1,0,0,0,0,0,0,0,0,0,0), 1'b1);
        @(posedge clk);
        #1;
        drive(mkv(R,FN_ADDU,5,5,6,0, 0,0,1,0,0,0,0,0,0,0,0,0,0), 1'b1);
        @(negedge clk);
        check("pre_reset_stall", 0, 1'b1, {2'b00, 2'b00, 1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, 2'b00, 5'd0});
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset", 0, 1'b1, nop.exp);
        @(posedge clk);
        #1;
        check("mid_reset_hold", 0, 1'b1, nop.exp);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset", 0, 1'b1, nop.exp);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
